// File: rtl/atconv_pkg.sv
// Shared types and constants for the atrous-convolution host.
// The ERR state only exists when ATCONV_HOST_WATCHDOG_EN is defined.
package atconv_pkg;

   localparam int IMG_DEPTH = 4096;
   localparam int L1_DEPTH  = 1024;
   localparam int DW        = 13;
   localparam int AW        = 12;

   typedef enum logic [2:0] {
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_RUN,
      S_DUMP
`ifdef ATCONV_HOST_WATCHDOG_EN
      ,
      S_ERR
`endif
   } state_t;

endpackage

// File: rtl/atconv_host_ram.sv
// Simple dual-read, single-write RAM: asynchronous reads, synchronous write.
// A read of the address being written returns the old word until the edge.
module atconv_host_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 13,
   parameter int ABITS = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ABITS-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ABITS-1:0] raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [ABITS-1:0] raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata_a = r_mem[raddr_a];
   assign rdata_b = r_mem[raddr_b];

endmodule

// File: rtl/atconv_host.sv
// Memory-side host for the atrous-convolution engine: loads the image,
// starts the engine, serves its reads/writes and streams layer 1 out.
// Optional watchdog (start timeout + run timeout, sticky err) is enabled
// by defining ATCONV_HOST_WATCHDOG_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------
// S_LOAD      | accept 4096 image words on the load stream
// S_START     | one-cycle ready pulse to the engine
// S_WAIT_BUSY | wait for engine to raise busy (layer writes honored)
// S_RUN       | engine running until busy falls (layer writes honored)
// S_DUMP      | stream layer1[0..1023], pulse done on the last accept
// S_ERR       | watchdog tripped; sticky until reset (watchdog only)
module atconv_host #(
   parameter int DW       = 13,
   parameter int AW       = 12,
   parameter int START_TO = 8,
   parameter int RUN_TO_W = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [DW-1:0]        ld_data,
   output logic                 ready,
   input  logic                 busy,
   input  logic [AW-1:0]        iaddr,
   output logic signed [DW-1:0] idata,
   input  logic                 cwr,
   input  logic [AW-1:0]        caddr_wr,
   input  logic [DW-1:0]        cdata_wr,
   input  logic                 csel,
   input  logic                 crd,
   input  logic [AW-1:0]        caddr_rd,
   output logic [DW-1:0]        cdata_rd,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [DW-1:0]        dump_data,
   output logic                 dump_last,
   output logic                 done,
   output logic                 err
);
   import atconv_pkg::*;

   localparam int L1W = $clog2(L1_DEPTH);

   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic          r_ld_ready;
   logic          r_ready;
   logic          r_dump_valid;
   logic          r_dump_last;
   logic          r_done;

   logic          w_ld_fire;
   logic          w_dump_fire;
   logic          w_c_wr_ok;
   logic [DW-1:0] w_img_rd;
   logic [DW-1:0] w_img_b;
   logic [DW-1:0] w_l0_rd;
   logic [DW-1:0] w_l0_b;
   logic [DW-1:0] w_l1_rd;
   logic [DW-1:0] w_l1_dump;
   logic          w_unused;

`ifdef ATCONV_HOST_WATCHDOG_EN
   localparam int SW = $clog2(START_TO + 2);
   logic [SW-1:0]       r_wd_start;
   logic [RUN_TO_W-1:0] r_wd_run;
   logic                r_err;
`endif

   // reset gates every write so a write sampled on a reset edge is dropped
   assign w_ld_fire   = ld_valid & r_ld_ready & ~reset;
   assign w_dump_fire = r_dump_valid & dump_ready;
   assign w_c_wr_ok   = cwr & ~reset & ((r_state == S_WAIT_BUSY) || (r_state == S_RUN));

   atconv_host_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
      .clk(clk), .we(w_ld_fire), .waddr(r_cnt), .wdata(ld_data),
      .raddr_a(iaddr), .rdata_a(w_img_rd), .raddr_b('0), .rdata_b(w_img_b)
   );

   atconv_host_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_layer0 (
      .clk(clk), .we(w_c_wr_ok & ~csel), .waddr(caddr_wr), .wdata(cdata_wr),
      .raddr_a(caddr_rd), .rdata_a(w_l0_rd), .raddr_b('0), .rdata_b(w_l0_b)
   );

   atconv_host_ram #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_layer1 (
      .clk(clk), .we(w_c_wr_ok & csel), .waddr(caddr_wr[L1W-1:0]), .wdata(cdata_wr),
      .raddr_a(caddr_rd[L1W-1:0]), .rdata_a(w_l1_rd),
      .raddr_b(r_cnt[L1W-1:0]), .rdata_b(w_l1_dump)
   );

   // sequencing FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_LOAD;
         r_cnt        <= '0;
         r_ld_ready   <= 1'b0;
         r_ready      <= 1'b0;
         r_dump_valid <= 1'b0;
         r_dump_last  <= 1'b0;
         r_done       <= 1'b0;
`ifdef ATCONV_HOST_WATCHDOG_EN
         r_wd_start   <= '0;
         r_wd_run     <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_ld_ready <= 1'b1;
               if (w_ld_fire) begin
                  r_cnt <= r_cnt + AW'(1);
                  if (r_cnt == AW'(IMG_DEPTH - 1)) begin
                     r_state    <= S_START;
                     r_ready    <= 1'b1;
                     r_ld_ready <= 1'b0;
                  end
               end
            end
            S_START: begin
               r_state <= S_WAIT_BUSY;
`ifdef ATCONV_HOST_WATCHDOG_EN
               r_wd_start <= SW'(START_TO);
`endif
            end
            S_WAIT_BUSY: begin
               if (busy) begin
                  r_state <= S_RUN;
`ifdef ATCONV_HOST_WATCHDOG_EN
                  r_wd_run <= '1;
               end else if (r_wd_start == '0) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_wd_start <= r_wd_start - SW'(1);
`endif
               end
            end
            S_RUN: begin
               if (!busy) begin
                  r_state      <= S_DUMP;
                  r_dump_valid <= 1'b1;
                  r_dump_last  <= 1'b0;
`ifdef ATCONV_HOST_WATCHDOG_EN
               end else if (r_wd_run == '0) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_wd_run <= r_wd_run - RUN_TO_W'(1);
`endif
               end
            end
            S_DUMP: begin
               if (w_dump_fire) begin
                  if (r_cnt[L1W-1:0] == L1W'(L1_DEPTH - 1)) begin
                     r_state      <= S_LOAD;
                     r_cnt        <= '0;
                     r_dump_valid <= 1'b0;
                     r_dump_last  <= 1'b0;
                     r_done       <= 1'b1;
                     r_ld_ready   <= 1'b1;
                  end else begin
                     r_cnt       <= r_cnt + AW'(1);
                     r_dump_last <= (r_cnt[L1W-1:0] == L1W'(L1_DEPTH - 2));
                  end
               end
            end
`ifdef ATCONV_HOST_WATCHDOG_EN
            S_ERR: begin
               r_err <= 1'b1;
            end
`endif
            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign ld_ready   = r_ld_ready;
   assign ready      = r_ready;
   assign dump_valid = r_dump_valid;
   assign dump_last  = r_dump_last;
   assign done       = r_done;
   assign idata      = w_img_rd;
   assign cdata_rd   = csel ? w_l1_rd : w_l0_rd;
   assign dump_data  = w_l1_dump;

`ifdef ATCONV_HOST_WATCHDOG_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // crd is a pure strobe from the engine; reads are never gated by it
   assign w_unused = ^{crd, w_img_b, w_l0_b, (START_TO > 0), (RUN_TO_W > 0)};

endmodule

// File: tb/tb_atconv_host.sv
// Bench for atconv_host: load, start, engine model, dump scoreboard,
// ignored writes, reset mid-operation, and start-timeout behaviour
// (watchdog expectations follow ATCONV_HOST_WATCHDOG_EN).
module tb_atconv_host;
   localparam int DW       = 13;
   localparam int AW       = 12;
   localparam int START_TO = 8;
   localparam int RUN_TO_W = 20;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 ld_valid = 1'b0;
   logic                 ld_ready;
   logic [DW-1:0]        ld_data = '0;
   logic                 ready;
   logic                 busy = 1'b0;
   logic [AW-1:0]        iaddr = '0;
   logic signed [DW-1:0] idata;
   logic                 cwr = 1'b0;
   logic [AW-1:0]        caddr_wr = '0;
   logic [DW-1:0]        cdata_wr = '0;
   logic                 csel = 1'b0;
   logic                 crd = 1'b0;
   logic [AW-1:0]        caddr_rd = '0;
   logic [DW-1:0]        cdata_rd;
   logic                 dump_valid;
   logic                 dump_ready = 1'b0;
   logic [DW-1:0]        dump_data;
   logic                 dump_last;
   logic                 done;
   logic                 err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] sb[$];

   atconv_host #(.DW(DW), .AW(AW), .START_TO(START_TO), .RUN_TO_W(RUN_TO_W)) dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel), .crd(crd),
      .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cwr = 1'b1; csel = sel; caddr_wr = a; cdata_wr = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready: got %b expected 0", ld_ready); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", ready); end
      n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dump_valid: got %b expected 0", dump_valid); end
      n_cmp++; if (dump_last !== 1'b0) begin n_bad++; $display("FAIL rst_dump_last: got %b expected 0", dump_last); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
      reset = 1'b0;
      step();
      n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ld_ready: got %b expected 1", ld_ready); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_ready: got %b expected 0", ready); end
   endtask

   // loads 4096 words (value i, or 4095-i when rev) with ld_valid toggling;
   // returns in the first WAIT_BUSY cycle
   task automatic test_load(input bit rev);
      int acc = 0;
      int cyc = 0;
      bit tog = 1'b0;
      bit fire;
      logic [DW-1:0] exp;
      while (acc < 4096 && cyc < 20000) begin
         ld_valid = tog;
         ld_data  = rev ? DW'(4095 - acc) : DW'(acc);
         fire = tog && (ld_ready === 1'b1);
         n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_early: got %b expected 0 at accept %0d", ready, acc); end
         step();
         if (fire) acc++;
         tog = ~tog;
         cyc++;
      end
      ld_valid = 1'b0;
      n_cmp++; if (acc != 4096) begin n_bad++; $display("FAIL load_timeout: got %0d accepts expected 4096", acc); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_pulse: got %b expected 1", ready); end
      n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL start_ld_ready: got %b expected 0", ld_ready); end
      iaddr = 12'h123; #1;
      exp = rev ? 13'hEDC : 13'h123;
      n_cmp++; if (idata !== exp) begin n_bad++; $display("FAIL idata_123: got %h expected %h", idata, exp); end
      iaddr = 12'hFFF; #1;
      exp = rev ? 13'h000 : 13'hFFF;
      n_cmp++; if (idata !== exp) begin n_bad++; $display("FAIL idata_fff: got %h expected %h", idata, exp); end
      step();
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ready_one_cycle: got %b expected 0", ready); end
   endtask

   // engine model: raise busy, do probe writes, then layer1[i]=i with the
   // last write on the same edge busy falls
   task automatic test_run();
      busy = 1'b1;
      step();
      drive_wr(1'b0, 12'd7, 13'h055); step();
      drive_wr(1'b0, 12'd5, 13'h0CD); step();
      drive_wr(1'b1, 12'd5, 13'h0AA); step();
      drive_wr(1'b1, 12'd5, 13'h0AB); caddr_rd = 12'd5; #1;
      n_cmp++; if (cdata_rd !== 13'h0AA) begin n_bad++; $display("FAIL same_cycle_old: got %h expected 0aa", cdata_rd); end
      step();
      cwr = 1'b0; csel = 1'b1; caddr_rd = 12'd5; #1;
      n_cmp++; if (cdata_rd !== 13'h0AB) begin n_bad++; $display("FAIL l1_read_new: got %h expected 0ab", cdata_rd); end
      csel = 1'b0; #1;
      n_cmp++; if (cdata_rd !== 13'h0CD) begin n_bad++; $display("FAIL l0_read_old: got %h expected 0cd", cdata_rd); end
      caddr_rd = 12'd7; #1;
      n_cmp++; if (cdata_rd !== 13'h055) begin n_bad++; $display("FAIL l0_read_7: got %h expected 055", cdata_rd); end
      n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL run_dump_valid: got %b expected 0", dump_valid); end
      for (int i = 0; i < 1024; i++) begin
         drive_wr(1'b1, (i % 2 == 1) ? (AW'(i) | 12'hC00) : AW'(i), DW'(i));
         busy = (i != 1023);
         sb.push_back(DW'(i));
         step();
      end
      cwr = 1'b0;
      busy = 1'b0;
   endtask

   task automatic test_dump();
      int cyc = 0;
      bit tog = 1'b0;
      bit fire;
      logic [DW-1:0] exp;
      drive_wr(1'b1, 12'd600, 13'h1FFF);
      while (sb.size() > 0 && cyc < 6000) begin
         dump_ready = tog;
         exp = sb[0];
         n_cmp++; if (dump_valid !== 1'b1) begin n_bad++; $display("FAIL dump_valid: got %b expected 1 at word %0d", dump_valid, exp); end
         n_cmp++; if (dump_data !== exp) begin n_bad++; $display("FAIL dump_data: got %0d expected %0d", dump_data, exp); end
         n_cmp++; if (dump_last !== (exp == 13'd1023)) begin n_bad++; $display("FAIL dump_last: got %b expected %b at word %0d", dump_last, (exp == 13'd1023), exp); end
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b expected 0 at word %0d", done, exp); end
         fire = tog && (dump_valid === 1'b1);
         step();
         cwr = 1'b0;
         if (fire) void'(sb.pop_front());
         tog = ~tog;
         cyc++;
      end
      dump_ready = 1'b0;
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL dump_timeout: got %0d words left expected 0", sb.size()); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got %b expected 1", done); end
      n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL done_ld_ready: got %b expected 1", ld_ready); end
      n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL done_dump_valid: got %b expected 0", dump_valid); end
      n_cmp++; if (dump_last !== 1'b0) begin n_bad++; $display("FAIL done_dump_last: got %b expected 0", dump_last); end
   endtask

   // called in the done cycle (already LOAD): a LOAD-time write is ignored
   task automatic test_back_to_back();
      drive_wr(1'b0, 12'd7, 13'h1FFF);
      caddr_rd = 12'd7;
      step();
      cwr = 1'b0; #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b expected 0", done); end
      n_cmp++; if (cdata_rd !== 13'h055) begin n_bad++; $display("FAIL load_write_ignored: got %h expected 055", cdata_rd); end
      test_load(1'b1);
   endtask

   // busy never rises after ready; t counts cycles from the ready cycle
   task automatic test_no_busy();
      logic exp_err;
      busy = 1'b0;
      for (int t = 1; t <= START_TO + 10; t++) begin
`ifdef ATCONV_HOST_WATCHDOG_EN
         exp_err = (t >= START_TO + 2);
`else
         exp_err = 1'b0;
`endif
         n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL wait_err: got %b expected %b at t=%0d", err, exp_err, t); end
         n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL wait_ready: got %b expected 0 at t=%0d", ready, t); end
         n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL wait_ld_ready: got %b expected 0 at t=%0d", ld_ready, t); end
         step();
      end
   endtask

   // reset while writes are otherwise legal: the write on the reset edge drops
   task automatic test_reset_mid();
      reset = 1'b1;
      drive_wr(1'b1, 12'd0, 13'h1FFF);
      step();
      reset = 1'b0;
      cwr = 1'b0;
      csel = 1'b1; caddr_rd = 12'd0; #1;
      n_cmp++; if (cdata_rd !== 13'd0) begin n_bad++; $display("FAIL reset_write_dropped: got %h expected 000", cdata_rd); end
      caddr_rd = 12'd600; #1;
      n_cmp++; if (cdata_rd !== 13'd600) begin n_bad++; $display("FAIL dump_write_ignored: got %0d expected 600", cdata_rd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b expected 0", err); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0", ready); end
      step();
      n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ld_ready: got %b expected 1", ld_ready); end
      iaddr = 12'h123; #1;
      n_cmp++; if (idata !== 13'hEDC) begin n_bad++; $display("FAIL image_persist: got %h expected edc", idata); end
   endtask

   initial begin
      test_reset();
      test_load(1'b0);
      test_run();
      test_dump();
      test_back_to_back();
      test_no_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/atconv_host.md
# atconv_host

Memory-side responder for the atrous-convolution engine. Holds the 64x64 input image ROM, the layer-0 (64x64) and layer-1 (32x32) result memories, loads the image from a streaming source, and starts the engine with a `ready` pulse. It serves the engine's combinational reads and synchronous writes, then streams layer 1 out once the engine drops `busy`.

## Interface
- `DW`, 13: pixel / result word width.
- `AW`, 12: image and layer-0 address width.
- `START_TO`, 8: cycles allowed for `busy` to rise after `ready`; used only with the watchdog.
- `RUN_TO_W`, 20: width of the run-time watchdog counter; used only with the watchdog.
- `clk` in 1: the only clock.
- `reset` in 1: reset is synchronous and active-high.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in DW: image load stream, row-major, 4096 words.
- `ready` out 1: one-cycle start pulse to the engine.
- `busy` in 1: engine busy.
- `iaddr` in AW, `idata` out DW signed: image read.
- `cwr` in 1, `caddr_wr` in AW, `cdata_wr` in DW, `csel` in 1: layer write.
- `crd` in 1, `caddr_rd` in AW, `cdata_rd` out DW: layer read.
- `dump_valid` out 1, `dump_ready` in 1, `dump_data` out DW, `dump_last` out 1: layer-1 output stream.
- `done` out 1: one-cycle pulse after the final dump word is accepted.
- `err` out 1: watchdog error, sticky.

## Operation
- States: LOAD, START, WAIT_BUSY, RUN, DUMP, plus ERR with the watchdog.
- LOAD (entered on reset):
  - `ld_ready`=1; each `ld_valid&ld_ready` writes `ld_data` to image[cnt] and increments the 12-bit `cnt`.
  - Accepting word 4095 moves to START and clears `cnt`.
- START: `ready`=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: moves to RUN on `busy`=1.
- RUN: moves to DUMP on the first cycle `busy`=0.
- Layer writes:
  - Honored only in WAIT_BUSY and RUN, at the edge where `cwr`=1.
  - `csel`=0 writes layer0[`caddr_wr`].
  - `csel`=1 writes layer1[`caddr_wr[9:0]`]; upper address bits are ignored.
  - `cwr` in any other state is ignored.
- Reads are combinational in every state:
  - `idata` = image[`iaddr`].
  - `cdata_rd` = `csel` ? layer1[`caddr_rd[9:0]`] : layer0[`caddr_rd`].
  - `crd` is accepted but does not gate the read.
- Read/write to the same address in the same cycle: the read returns the old data, and the new data is visible the next cycle.
- DUMP:
  - `dump_valid`=1 and `dump_data` = layer1[`cnt[9:0]`].
  - `cnt` advances on `dump_valid&dump_ready`.
  - `dump_last`=1 while `cnt`=1023.
  - Accepting the last word pulses `done` and returns to LOAD with `cnt`=0.
- Memories are not cleared by reset; their contents persist across images.
- Reset mid-operation: the FSM goes to LOAD and `cnt`=0 at the next edge. Any write sampled on that edge is dropped.

## Timing
- Reset values: `ld_ready`=0 during reset and 1 from the first cycle after reset. `ready`=0, `dump_valid`=0, `dump_last`=0, `done`=0, `err`=0.
- `idata` and `cdata_rd` are combinational, 0-cycle latency, and not reset.
- `ready` rises on the cycle after the 4096th load accept.
- The engine raises `busy` one cycle after sampling `ready`.
- The final engine write and the fall of `busy` share an edge; that write is honored because the state is still RUN.
- `dump_data` is valid in the same cycle as `dump_valid`. It holds stable while `dump_valid&!dump_ready`.
- `done` is asserted in the cycle after the last accept, which is also the first LOAD cycle.

## Configuration
- `ATCONV_HOST_WATCHDOG_EN` defined:
  - WAIT_BUSY longer than `START_TO` cycles goes to ERR.
  - RUN counter saturating at 2^`RUN_TO_W`-1 goes to ERR.
  - ERR: `err`=1, `ready`/`ld_ready`/`dump_valid`=0, writes ignored, reads still served. Exit only via reset.
- Undefined: no counters and no ERR state; `err` is tied to 0.

## Structure
- `atconv_pkg`: state enum; constants `IMG_DEPTH`=4096, `L1_DEPTH`=1024, `DW`=13, `AW`=12.
- Sub-module `atconv_host_ram`: parameterized depth and width, asynchronous read, synchronous write. Instantiated for image, layer0 and layer1.

## Test plan
- Reset -> `ready`=0, `dump_valid`=0, `err`=0; `ld_ready`=1 on the first post-reset cycle.
- Load pixels value=i with `ld_valid` toggling each cycle -> exactly one `ready` pulse, the cycle after the 4096th accept. `iaddr`=0x123 then returns `idata`=0x123 in the same cycle.
- In RUN: `cwr`=1, `csel`=1, `caddr_wr`=5, `cdata_wr`=0x0AB -> next cycle `csel`=1, `caddr_rd`=5 gives 0x0AB; `csel`=0, addr 5 gives the old layer0 value. A same-cycle read returns the old value.
- `cwr`=1 during LOAD, addr 7, 0x1FFF -> after the run, layer0[7] is unchanged.
- Model engine drops `busy` after writing layer1[i]=i; `dump_ready` toggles each cycle -> 1024 words 0..1023 in order, `dump_last` only on 1023, `done` pulse, `ld_ready`=1 again.
- With `ATCONV_HOST_WATCHDOG_EN`: `busy` held 0 after `ready` -> `err`=1 after `START_TO`+1 cycles and stays 1 until reset. Without the macro, the FSM waits indefinitely and `err` stays 0.
